// File: rtl/multdiv_pkg.sv
// multdiv_pkg
//   Shared definitions for the iterative multiply/divide unit: FSM state
//   encoding, iteration counts, the most negative 32-bit value and a small
//   helper that turns a two's complement word into its unsigned magnitude.
package multdiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [4:0]  MUL_ITER = 5'd16;
  localparam int          DIV_ITER = 32;
  // The 5-bit counter cannot hold 32, so divide stops on the last index.
  localparam logic [4:0]  DIV_LAST = 5'(DIV_ITER - 1);
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  // Magnitude of a two's complement word. INT_MIN maps to 0x80000000,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] value);
    return value[31] ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/multdiv_booth_recode.sv
// booth_recode
//   Radix-4 Booth recoder. Turns a 3-bit multiplier window
//   {b[i+1], b[i], b[i-1]} into the partial-product selection.
//   Ports:
//     window  in  3  multiplier bits of the current iteration
//     sub     out 1  subtract the selected multiple instead of adding it
//     zero    out 1  partial product is zero
//     dbl     out 1  select 2*A instead of A
module booth_recode
(
  input  logic [2:0] window,
  output logic       sub,
  output logic       zero,
  output logic       dbl
);

  always_comb begin
    sub  = 1'b0;
    zero = 1'b0;
    dbl  = 1'b0;
    unique case (window)
      3'b000, 3'b111: zero = 1'b1;
      3'b001, 3'b010: sub  = 1'b0;
      3'b011:         dbl  = 1'b1;
      3'b100: begin
        sub = 1'b1;
        dbl = 1'b1;
      end
      3'b101, 3'b110: sub  = 1'b1;
      default:        zero = 1'b1;
    endcase
  end

endmodule

// File: rtl/multdiv.sv
// multdiv
//   Iterative signed 32-bit multiply/divide unit. Multiply uses radix-4
//   Booth (16 iterations); divide uses non-restoring division (32
//   iterations) followed by a sign-fix cycle. One 34-bit add/subtract is
//   shared by both operations.
//   Ports:
//     clock           in  1   rising-edge clock
//     reset           in  1   synchronous active-high reset
//     data_operandA   in  32  multiplicand / dividend
//     data_operandB   in  32  multiplier / divisor
//     ctrl_MULT       in  1   start pulse, multiply (wins over ctrl_DIV)
//     ctrl_DIV        in  1   start pulse, divide
//     data_result     out 32  product low word / quotient, registered
//     data_exception  out 1   overflow or divide error, registered
//     data_resultRDY  out 1   one-cycle completion pulse
module multdiv
  import multdiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] prod_q, prod_d;
  logic [33:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] opnd_q, opnd_d;
  logic        conv_q, conv_d;
  logic        neg_q, neg_d;
  logic        ovf_q, ovf_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;

  logic        booth_sub, booth_zero, booth_dbl;
  logic [33:0] mcand;
  logic [33:0] add_a, add_b, add_sum;
  logic        add_sub;

  booth_recode u_booth (
    .window (prod_q[2:0]),
    .sub    (booth_sub),
    .zero   (booth_zero),
    .dbl    (booth_dbl)
  );

  // Shared adder operands. Multiply adds the Booth multiple into the
  // sign-extended upper product word; divide adds or subtracts the divisor
  // from the left-shifted partial remainder depending on its sign.
  always_comb begin
    mcand   = {{2{opnd_q[31]}}, opnd_q};
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    if (state_q == ST_MUL) begin
      add_a   = {{2{prod_q[64]}}, prod_q[64:33]};
      add_b   = booth_zero ? '0 : (booth_dbl ? {mcand[32:0], 1'b0} : mcand);
      add_sub = booth_sub;
    end else begin
      add_a   = {rem_q[32:0], quo_q[31]};
      add_b   = {2'b00, opnd_q};
      add_sub = ~rem_q[33];
    end
  end

  assign add_sum = add_a + (add_b ^ {34{add_sub}}) + {33'd0, add_sub};

  // Next-state and datapath. A start pulse in any state aborts whatever was
  // running. Outputs are loaded on the edge that enters DONE so that the
  // RDY pulse and the new result appear together for the DONE cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    opnd_d   = opnd_q;
    conv_d   = conv_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    if (ctrl_MULT) begin
      state_d = ST_MUL;
      cnt_d   = '0;
      prod_d  = {32'd0, data_operandB, 1'b0};
      opnd_d  = data_operandA;
    end else if (ctrl_DIV) begin
      state_d = ST_DIV;
      cnt_d   = '0;
      conv_d  = 1'b1;
      quo_d   = data_operandA;
      opnd_d  = data_operandB;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_MUL: begin
          if (cnt_q == MUL_ITER) begin
            state_d  = ST_DONE;
            result_d = prod_q[32:1];
            // Overflow when bits 63..31 of the product are not a pure sign.
            exc_d    = !((prod_q[64:32] == '0) || (&prod_q[64:32]));
            rdy_d    = 1'b1;
          end else begin
            prod_d = {add_sum, prod_q[32:2]};
            cnt_d  = cnt_q + 5'd1;
          end
        end
        ST_DIV: begin
          if (conv_q) begin
            // First divide cycle: raw operands become magnitudes.
            conv_d = 1'b0;
            cnt_d  = '0;
            if (opnd_q == '0) begin
              state_d  = ST_DONE;
              result_d = '0;
              exc_d    = 1'b1;
              rdy_d    = 1'b1;
            end else begin
              neg_d  = quo_q[31] ^ opnd_q[31];
              ovf_d  = (quo_q == INT_MIN) && (opnd_q == '1);
              quo_d  = magnitude(quo_q);
              opnd_d = magnitude(opnd_q);
              rem_d  = '0;
            end
          end else begin
            rem_d = add_sum;
            quo_d = {quo_q[30:0], ~add_sum[33]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == DIV_LAST) begin
              state_d = ST_FIX;
            end
          end
        end
        ST_FIX: begin
          state_d  = ST_DONE;
          result_d = ovf_q ? INT_MIN : (neg_q ? (~quo_q + 32'd1) : quo_q);
          exc_d    = ovf_q;
          rdy_d    = 1'b1;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      opnd_q   <= '0;
      conv_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      opnd_q   <= opnd_d;
      conv_q   <= conv_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv
//   Self-checking bench for multdiv. A behavioural model predicts, from
//   plain signed arithmetic and fixed latencies, when RDY pulses and what
//   result/exception must be held; a compare process checks the DUT against
//   it every cycle. Directed operations also check literal expectations.
module tb_multdiv;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Model state
  bit          m_pend = 1'b0;
  int          m_left = 0;
  logic [31:0] m_res = '0;
  logic        m_exc = 1'b0;
  logic        exp_rdy = 1'b0;
  logic [31:0] exp_result = '0;
  logic        exp_exc = 1'b0;

  multdiv dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: compute the answer with ordinary arithmetic when an
  // operation starts, then count down its fixed latency.
  always @(posedge clock) begin
    logic signed [63:0] p;
    logic signed [31:0] sa, sb;
    exp_rdy = 1'b0;
    if (reset) begin
      m_pend     = 1'b0;
      exp_result = '0;
      exp_exc    = 1'b0;
    end else if (ctrl_MULT || ctrl_DIV) begin
      sa = data_operandA;
      sb = data_operandB;
      m_pend = 1'b1;
      if (ctrl_MULT) begin
        p      = 64'(sa) * 64'(sb);
        m_res  = p[31:0];
        m_exc  = !((p[63:31] == '0) || (p[63:31] == '1));
        m_left = 17;
      end else if (sb == 0) begin
        m_res  = '0;
        m_exc  = 1'b1;
        m_left = 1;
      end else if (sa == 32'sh8000_0000 && sb == -32'sd1) begin
        m_res  = 32'h8000_0000;
        m_exc  = 1'b1;
        m_left = 34;
      end else begin
        m_res  = sa / sb;
        m_exc  = 1'b0;
        m_left = 34;
      end
    end else if (m_pend) begin
      m_left--;
      if (m_left == 0) begin
        m_pend     = 1'b0;
        exp_rdy    = 1'b1;
        exp_result = m_res;
        exp_exc    = m_exc;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check_output("cyc_rdy", 32'(data_resultRDY), 32'(exp_rdy));
      check_output("cyc_result", data_result, exp_result);
      check_output("cyc_exception", 32'(data_exception), 32'(exp_exc));
    end
  end

  // Start one operation, scramble operands afterwards, wait (bounded) for
  // RDY and check latency, result and exception against literals.
  task automatic apply_stimulus(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                input int exp_lat, input logic [31:0] exp_res,
                                input logic exp_ex, input string name);
    int  n;
    bit  seen;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = is_mul;
    ctrl_DIV      = !is_mul;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clock);
      #1;
      n++;
      if (data_resultRDY) seen = 1'b1;
    end
    check_output({name, "_latency"}, 32'(n), 32'(exp_lat));
    check_output({name, "_result"}, data_result, exp_res);
    check_output({name, "_exception"}, 32'(data_exception), 32'(exp_ex));
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    int rdy_count;
    repeat (2) @(posedge clock);
    #1;
    reset  = 1'b0;
    cmp_en = 1'b1;
    check_output("reset_result", data_result, 32'h0);
    check_output("reset_exception", 32'(data_exception), 32'h0);
    check_output("reset_rdy", 32'(data_resultRDY), 32'h0);
    @(posedge clock);
    #1;

    apply_stimulus(1, 32'd3,          32'hFFFF_FFF9, 17, 32'hFFFF_FFEB, 1'b0, "mul_3_m7");
    apply_stimulus(1, 32'h0001_0000,  32'h0001_0000, 17, 32'h0000_0000, 1'b1, "mul_ovf");
    apply_stimulus(1, 32'h0000_FFFF,  32'h0001_0000, 17, 32'hFFFF_0000, 1'b1, "mul_bit31");
    apply_stimulus(1, 32'h8000_0000,  32'd1,         17, 32'h8000_0000, 1'b0, "mul_intmin_1");
    apply_stimulus(1, 32'h8000_0000,  32'h8000_0000, 17, 32'h0000_0000, 1'b1, "mul_intmin_sq");
    apply_stimulus(1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 17, 32'h0000_0001, 1'b0, "mul_m1_m1");
    apply_stimulus(0, 32'hFFFF_FFF9,  32'd2,         34, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
    apply_stimulus(0, 32'd5,          32'd0,          1, 32'h0000_0000, 1'b1, "div_by_zero");
    apply_stimulus(0, 32'h8000_0000,  32'hFFFF_FFFF, 34, 32'h8000_0000, 1'b1, "div_intmin_m1");
    apply_stimulus(0, 32'd100,        32'd7,         34, 32'd14,        1'b0, "div_100_7");
    apply_stimulus(0, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 34, 32'd14,        1'b0, "div_m100_m7");
    apply_stimulus(0, 32'd7,          32'hFFFF_FF9C, 34, 32'd0,         1'b0, "div_7_m100");
    apply_stimulus(0, 32'h8000_0000,  32'd2,         34, 32'hC000_0000, 1'b0, "div_intmin_2");
    apply_stimulus(0, 32'h7FFF_FFFF,  32'd1,         34, 32'h7FFF_FFFF, 1'b0, "div_max_1");

    // Abort a divide with a multiply at edge k+10.
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV  = 1'b0;
    rdy_count = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_count++;
    end
    check_output("abort_quiet", 32'(rdy_count), 32'd0);
    apply_stimulus(1, 32'd6, 32'd7, 17, 32'd42, 1'b0, "abort_mul");

    // Reset at edge k+5 of a divide: no RDY, outputs cleared.
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    rdy_count = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_count++;
    end
    check_output("reset_mid_rdy", 32'(rdy_count), 32'd0);
    check_output("reset_mid_result", data_result, 32'h0);
    check_output("reset_mid_exception", 32'(data_exception), 32'h0);

    // Reset together with a start pulse: the start is ignored.
    data_operandA = 32'd3;
    data_operandB = 32'd5;
    reset         = 1'b1;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    reset     = 1'b0;
    ctrl_MULT = 1'b0;
    rdy_count = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_count++;
    end
    check_output("reset_start_rdy", 32'(rdy_count), 32'd0);

    @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
